// File: rtl/cmos_capture_pair.sv
// CMOS sensor capture: pairs 8-bit bytes into RGB565 pixels.
// Optional frame stats behind CMOS_CAPTURE_STAT_EN.
module cmos_capture_pair #(
  parameter int WAIT_FRAMES = 10,
  parameter int BYTE_ORDER  = 0
) (
  input  logic        cam_pclk,
  input  logic        rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        cmos_vsync,
  output logic        cmos_href,
  output logic [15:0] cmos_data,
  output logic        cmos_data_valid
`ifdef CMOS_CAPTURE_STAT_EN
  ,
  output logic [11:0] stat_pixels,
  output logic [11:0] stat_lines,
  output logic        stat_valid
`endif
);

  localparam int CW =
    (WAIT_FRAMES < 1) ? 1 : $clog2(WAIT_FRAMES + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_FRAMES);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic            s1_vsync;
  logic            s1_vsync_d;
  logic            s1_href;
  logic [7:0]      s1_data;
  logic            phase_q;
  logic [7:0]      first_q;
  logic            frame_start;
  logic            pix_fire;
  logic [15:0]     pix_word;
  logic            run_en;
  logic            vsync_d;
  logic            href_d;
  logic            valid_d;
  logic [15:0]     data_d;

  // S1: register raw sensor pins before any decision logic
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vsync   <= 1'b0;
      s1_vsync_d <= 1'b0;
      s1_href    <= 1'b0;
      s1_data    <= 8'h00;
    end else begin
      s1_vsync   <= cam_vsync;
      s1_vsync_d <= s1_vsync;
      s1_href    <= cam_href;
      s1_data    <= cam_data;
    end
  end

  assign frame_start = s1_vsync & ~s1_vsync_d;

  // State register
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_WAIT;
    else        state_q <= state_d;
  end

  // Next state: leave WAIT only on a frame start once settled
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      (state_q == ST_WAIT): begin
        if (frame_start && (cnt_q == WAIT_MAX))
          state_d = ST_RUN;
      end
      (state_q == ST_RUN): state_d = ST_RUN;
    endcase
  end

  // Discarded-frame counter, frozen once running
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if ((state_q == ST_WAIT) && frame_start
             && (cnt_q < WAIT_MAX))
      cnt_q <= cnt_q + 1'b1;
  end

  // Byte phase and pending first byte of the pixel
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      first_q <= 8'h00;
    end else begin
      if (!s1_href) phase_q <= 1'b0;
      else          phase_q <= ~phase_q;
      if (s1_href && !phase_q)
        first_q <= s1_data;
    end
  end

  assign pix_fire = s1_href & phase_q;
  assign pix_word = (BYTE_ORDER == 1) ?
                    {s1_data, first_q} :
                    {first_q, s1_data};
  // Includes the frame-start cycle that enters RUN
  assign run_en   = (state_d == ST_RUN);

  // Output comb: gate everything until running
  always_comb begin
    vsync_d = run_en & s1_vsync;
    href_d  = run_en & s1_href;
    valid_d = run_en & pix_fire;
    data_d  = cmos_data;
    if (valid_d) data_d = pix_word;
  end

  // Output register, second stage of the pipeline
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      cmos_vsync      <= 1'b0;
      cmos_href       <= 1'b0;
      cmos_data       <= 16'h0000;
      cmos_data_valid <= 1'b0;
    end else begin
      cmos_vsync      <= vsync_d;
      cmos_href       <= href_d;
      cmos_data       <= data_d;
      cmos_data_valid <= valid_d;
    end
  end

`ifdef CMOS_CAPTURE_STAT_EN
  logic        s1_href_d;
  logic        line_end;
  logic [11:0] pix_cnt;
  logic [11:0] last_pix;
  logic [11:0] line_cnt;

  assign line_end = s1_href_d & ~s1_href;

  // Per-line pixel and per-frame line counters, saturating
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_href_d <= 1'b0;
      pix_cnt   <= 12'd0;
      last_pix  <= 12'd0;
      line_cnt  <= 12'd0;
    end else begin
      s1_href_d <= s1_href;
      if (line_end) begin
        last_pix <= pix_cnt;
        pix_cnt  <= 12'd0;
      end else if (pix_fire && (pix_cnt != 12'hFFF)) begin
        pix_cnt <= pix_cnt + 12'd1;
      end
      if (frame_start)
        line_cnt <= 12'd0;
      else if (line_end && (line_cnt != 12'hFFF))
        line_cnt <= line_cnt + 12'd1;
    end
  end

  // Publish previous-frame stats at each running frame start
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pixels <= 12'd0;
      stat_lines  <= 12'd0;
      stat_valid  <= 1'b0;
    end else begin
      stat_valid <= frame_start && (state_q == ST_RUN);
      if (frame_start && (state_q == ST_RUN)) begin
        stat_pixels <= last_pix;
        stat_lines  <= line_cnt;
      end
    end
  end
`endif

endmodule

// File: doc/cmos_capture_pair.md
CMOS_CAPTURE_PAIR -- requirements
Module: cmos_capture_pair

Interface
REQ-001 SHALL have parameter WAIT_FRAMES, default 10: number of whole sensor frames discarded after reset (sensor register settle time).
REQ-002 SHALL have parameter BYTE_ORDER, default 0: 0 = first byte of a pixel is the high byte; 1 = first byte is the low byte.
REQ-003 SHALL have port cam_pclk, input, 1: pixel clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cam_vsync, input, 1: sensor frame sync; active-high pulse, rising edge starts a frame.
REQ-006 SHALL have port cam_href, input, 1: sensor line valid, active-high.
REQ-007 SHALL have port cam_data, input, 8: sensor byte stream, two bytes per RGB565 pixel.
REQ-008 SHALL have port cmos_vsync, output, 1: gated, delayed frame sync for the downstream cropper.
REQ-009 SHALL have port cmos_href, output, 1: gated, delayed line valid.
REQ-010 SHALL have port cmos_data, output, 16: assembled RGB565 pixel.
REQ-011 SHALL have port cmos_data_valid, output, 1: one-cycle qualifier per assembled pixel.

Function
REQ-012 SHALL register cam_vsync, cam_href and cam_data once (stage S1) before any decision logic.
REQ-013 SHALL detect a frame start as S1 vsync high while the previous S1 vsync sample was low.
REQ-014 SHALL implement two states, WAIT and RUN; the state is WAIT out of reset.
REQ-015 In WAIT, SHALL count frame starts in a counter wide enough for WAIT_FRAMES; while the count is below WAIT_FRAMES, each frame start SHALL increment it.
REQ-016 SHALL move WAIT->RUN on a frame start that occurs while the count equals WAIT_FRAMES, so output always begins on a whole frame.
REQ-017 With WAIT_FRAMES=0, SHALL enter RUN on the first frame start after reset.
REQ-018 RUN SHALL be terminal until reset; the counter SHALL then hold.
REQ-019 SHALL keep a byte-phase flag: cleared while S1 href is low; toggled on each cycle S1 href is high.
REQ-020 On a phase-0 byte, SHALL store the byte as the pending first byte.
REQ-021 On a phase-1 byte, SHALL form cmos_data as {first,second} if BYTE_ORDER=0, or {second,first} if BYTE_ORDER=1, and SHALL assert cmos_data_valid for exactly one cycle.
REQ-022 The output register SHALL update on the edge after the S1 capture of the second byte, giving 2 cam_pclk edges of latency from a byte on the pins to cmos_data/cmos_data_valid.
REQ-023 cmos_vsync and cmos_href SHALL be the S1 signals delayed one further register, so all outputs are aligned at 2-cycle latency.
REQ-024 An odd trailing byte at line end (href falls at phase 1) SHALL be discarded, with no valid pulse generated.
REQ-025 While the state is WAIT, cmos_vsync, cmos_href and cmos_data_valid SHALL be 0 and cmos_data SHALL hold 0.
REQ-026 On the frame-start cycle that enters RUN, cmos_vsync SHALL pass high, so downstream logic sees the rising edge.
REQ-027 While cmos_data_valid is 0, cmos_data SHALL hold its last value.

Reset
REQ-028 When rst_n is low, SHALL asynchronously clear state to WAIT, the frame counter, the phase flag, the pending byte, all S1 registers, and all outputs to 0.
REQ-029 A reset asserted mid-frame in RUN SHALL restart the full WAIT_FRAMES discard sequence.

Configuration
REQ-030 When macro CMOS_CAPTURE_STAT_EN is defined, SHALL add outputs stat_pixels[11:0], stat_lines[11:0] and stat_valid[1].
REQ-031 With CMOS_CAPTURE_STAT_EN defined and the state in RUN, on each frame start SHALL latch the pixel count of the last complete line and the line count (href falling edges) of the previous frame, and SHALL pulse stat_valid for one cycle; the stat counters SHALL saturate at 4095.
REQ-032 Without CMOS_CAPTURE_STAT_EN, SHALL omit these ports and counters, with no other behavioural change.

Verification
REQ-033 Reset, WAIT_FRAMES=2, 3 frames -> no output activity in frames 1-2; cmos_vsync rises with frame 3.
REQ-034 RUN, BYTE_ORDER=0, bytes 0xF8,0x1F -> cmos_data=16'hF81F with one valid pulse 2 edges after 0x1F is presented.
REQ-035 BYTE_ORDER=1, same bytes -> cmos_data=16'h1FF8.
REQ-036 Line of 7 bytes -> exactly 3 valid pulses; the 7th byte is dropped, and the next line starts at phase 0.
REQ-037 rst_n pulsed low mid-line in RUN -> outputs 0 immediately, then WAIT_FRAMES frames suppressed again.
REQ-038 CMOS_CAPTURE_STAT_EN, frames of 4 lines x 1280 pixels -> stat_pixels=1280, stat_lines=4, stat_valid for 1 cycle at the next frame start.
